// File: rtl/sym_fir_pkg.sv
// Shared constants and helpers for the symmetric FIR pipeline.
// Derived sizes are functions so every file computes them the same way.
package sym_fir_pkg;

    localparam int DEF_DW    = 18;
    localparam int DEF_CW    = 18;
    localparam int DEF_NTAPS = 21;
    localparam int DEF_OW    = 18;
    localparam int DEF_SHIFT = 17;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Unique coefficients of an odd-length symmetric response.
    function automatic int calc_h(input int ntaps);
        return (ntaps + 1) / 2;
    endfunction

    // Registered levels in the adder tree.
    function automatic int calc_t(input int ntaps);
        return clog2(calc_h(ntaps));
    endfunction

    function automatic int calc_aw(input int dw, input int cw, input int ntaps);
        return dw + cw + 1 + calc_t(ntaps);
    endfunction

    function automatic int calc_lat(input int ntaps);
        return 4 + calc_t(ntaps);
    endfunction

    localparam int DEF_H = calc_h(DEF_NTAPS);

    typedef logic signed [DEF_CW-1:0] coef_bank_t [DEF_H];

endpackage

// File: rtl/sym_fir_addtree.sv
// Pipelined pairwise adder tree: N signed inputs reduced over T registered levels,
// with a valid bit carried alongside the data.
module sym_fir_addtree #(
    parameter int N  = 11,
    parameter int IW = 37,
    parameter int T  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_data [N],
    output logic                 out_valid,
    output logic signed [IW+T-1:0] out_data
);

    localparam int SW = IW + T;
    localparam int S  = N + 1;
    localparam int P  = S / 2;

    logic signed [SW-1:0] ext  [S];
    logic signed [SW-1:0] node [T][S];
    logic [T-1:0]         vld;

    // Unused slots stay zero, so an odd element simply adds zero and is
    // carried to the next level through a register.
    always_comb begin
        for (int i = 0; i < S; i++) ext[i] = '0;
        for (int i = 0; i < N; i++) ext[i] = SW'(in_data[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < T; l++)
                for (int i = 0; i < S; i++)
                    node[l][i] <= '0;
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 0; i < P; i++)
                node[0][i] <= ext[2*i] + ext[2*i+1];
            for (int l = 1; l < T; l++) begin
                vld[l] <= vld[l-1];
                for (int i = 0; i < P; i++)
                    node[l][i] <= node[l-1][2*i] + node[l-1][2*i+1];
            end
        end
    end

    assign out_valid = vld[T-1];
    assign out_data  = node[T-1][0];

endmodule

// File: rtl/sym_fir_pipe.sv
// Fully pipelined odd-length symmetric FIR with double-buffered coefficients.
// Define SYM_FIR_SAT_EN to clamp the output instead of wrapping it.
module sym_fir_pipe
    import sym_fir_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW,
    parameter int NTAPS = DEF_NTAPS,
    parameter int OW    = DEF_OW,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic signed [DW-1:0]               in_data,
    input  logic                               coef_we,
    input  logic [clog2(calc_h(NTAPS))-1:0]    coef_addr,
    input  logic signed [CW-1:0]               coef_data,
    input  logic                               coef_swap,
    output logic                               swap_pend,
    output logic                               out_valid,
    output logic signed [OW-1:0]               out_data
);

    localparam int H  = calc_h(NTAPS);
    localparam int T  = calc_t(NTAPS);
    localparam int AW = calc_aw(DW, CW, NTAPS);
    localparam int AB = clog2(H);
    localparam int PW = DW + 1;
    localparam int MW = DW + 1 + CW;

    typedef logic signed [CW-1:0] bank_t [H];

    // in_valid is a one-way strobe with no backpressure: a sample is taken on
    // every cycle it is high, and out_valid follows it exactly LAT cycles later.
    logic signed [DW-1:0] x [NTAPS];
    logic                 v_x, v_p, v_m, v_t;
    bank_t                shadow, shadow_nxt, c_act, c_p;
    logic                 do_copy;
    logic signed [PW-1:0] p [H];
    logic signed [MW-1:0] m [H];
    logic signed [AW-1:0] acc;

    always_comb begin
        shadow_nxt = shadow;
        if (coef_we && ({1'b0, coef_addr} < (AB+1)'(H)))
            shadow_nxt[coef_addr] = coef_data;
    end

    assign do_copy = in_valid && swap_pend;

    // A write landing in the copy cycle goes straight through to the active bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= '{default: '0};
            v_x       <= 1'b0;
            shadow    <= '{default: '0};
            c_act     <= '{default: '0};
            swap_pend <= 1'b0;
        end else begin
            v_x <= in_valid;
            if (in_valid) begin
                x[0] <= in_data;
                for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            end
            shadow    <= shadow_nxt;
            if (do_copy) c_act <= shadow_nxt;
            swap_pend <= coef_swap | (swap_pend & ~do_copy);
        end
    end

    // c_act is sampled next to the pre-added data, so a swap only affects
    // samples accepted on or after the copy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            p   <= '{default: '0};
            c_p <= '{default: '0};
            v_p <= 1'b0;
            m   <= '{default: '0};
            v_m <= 1'b0;
        end else begin
            v_p <= v_x;
            c_p <= c_act;
            for (int k = 0; k < H - 1; k++)
                p[k] <= PW'(x[k]) + PW'(x[NTAPS-1-k]);
            p[H-1] <= PW'(x[H-1]);
            v_m <= v_p;
            for (int k = 0; k < H; k++)
                m[k] <= MW'(p[k]) * MW'(c_p[k]);
        end
    end

    sym_fir_addtree #(
        .N  (H),
        .IW (MW),
        .T  (T)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v_m),
        .in_data   (m),
        .out_valid (v_t),
        .out_data  (acc)
    );

    localparam logic signed [AW:0] HALF = (AW+1)'(1) <<< (SHIFT - 1);

    logic signed [AW:0]   rnd, shd;
    logic signed [OW-1:0] r_out;

    always_comb begin
        rnd = (AW+1)'(acc) + HALF;
        shd = rnd >>> SHIFT;
    end

`ifdef SYM_FIR_SAT_EN
    localparam logic signed [AW:0] OMAX = (AW+1)'(2**(OW-1) - 1);
    localparam logic signed [AW:0] OMIN = ~OMAX;

    always_comb begin
        if (shd > OMAX)      r_out = OW'(OMAX);
        else if (shd < OMIN) r_out = OW'(OMIN);
        else                 r_out = OW'(shd);
    end
`else
    assign r_out = OW'(shd);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= v_t;
            if (v_t) out_data <= r_out;
        end
    end

endmodule
